mem_stage_dual: RTL and testbench
=================================

# mem_stage_dual

Dual-lane MEM stage output block: the transmitting end of the MEM→WB valid/allowin handshake consumed by `wb_stage`. It holds one instruction pair from EXE, waits for the data-SRAM response of a load, and merges the aligned, extended load data into the result field. It then presents each lane to WB with `ms1_to_ws_*` / `ms2_to_ws_*`, guaranteeing lane 1 (older) is never transferred after lane 2. It also drives MEM-level forwarding for the ID stage.

## Interface
- Parameters: none. Bus widths come from `mycpu.h`: `MS_TO_WS_BUS_WD`=133 and `ES_TO_MS_BUS_WD`=139.
- Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ms_allowin` out 1: the pair may be accepted from EXE.
- `es1_to_ms_valid` in 1: EXE lane 1 valid.
- `es1_to_ms_bus` in 139: lane 1 bus, {ld_en[138], ld_type[137:135], addr_lo[134:133], ws_base[132:0]}.
- `es2_to_ms_valid` in 1: EXE lane 2 valid.
- `es2_to_ms_bus` in 139: lane 2 bus, same layout as lane 1.
- `data_sram_data_ok` in 1: load response strobe.
- `data_sram_rdata` in 32: load response data.
- `ms_flush` in 1: exception/eret flush.
- `ms1_to_ws_valid` out 1: lane 1 valid to WB.
- `ms1_to_ws_bus` out 133: lane 1 bus to WB.
- `ms2_to_ws_valid` out 1: lane 2 valid to WB.
- `ms2_to_ws_bus` out 133: lane 2 bus to WB.
- `ws_allowin_1` in 1: WB accepts lane 1.
- `ws_allowin_2` in 1: WB accepts lane 2.
- `ms1_reg` out 42: lane 1 forward, {data_ok[41], gr_we[40:37], dest[36:32], result[31:0]}.
- `ms2_reg` out 42: lane 2 forward, same layout as lane 1.

## Operation
- Per-lane registers: `valid`, `sent`, `bus`. Shared registers: `ld_pend`, `ld_buf_vld`, `ld_buf`, `discard`.
- Capture: when `ms_allowin`, load both lanes from EXE, clear both `sent` flags, and set `ld_pend` if either lane's `ld_en`. At most one load per pair; EXE guarantees this.
- `ms_allowin` = (neither lane valid) OR (every valid lane is sent or completing this cycle). It is forced to 0 while `discard`=1.
- A lane is ready when it is not a load, or when `ld_buf_vld`=1, or when `data_sram_data_ok`=1 this cycle (bypass).
- `msN_to_ws_valid` = `validN` & ~`sentN` & `readyN`. For lane 2 the additional term is (`sent1` OR lane 1 transferring this cycle OR lane 1 invalid).
- A transfer fires when `msN_to_ws_valid` & `ws_allowin_N`. The lane's `sent` is then set.
- Load merge selects bytes of the response word:
  - by `ld_type`: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu;
  - by `addr_lo`: byte `addr_lo`, or halfword `addr_lo[1]`;
  - extension is sign or zero per type;
  - the result replaces ws_base[63:32]. All other fields pass unchanged.
- A load with ws_base ex bit[122]=1 has no request in flight. `ld_pend` is not set and the lane is ready immediately.
- Flush: `ms_flush` clears both `valid` flags and `ld_buf_vld`. If `ld_pend` is set and no `data_ok` arrives that cycle, `discard` is set. The next `data_ok` clears `discard` and is dropped.
- Forward: `data_ok` is 0 for a valid load that is not yet ready. `gr_we` is masked to 0 when the lane is invalid or sent.

## Timing
- Reset: all valid/sent/`ld_pend`/`ld_buf_vld`/`discard` are 0.
- Output values on reset:
  - `ms_allowin`=1;
  - `ms1_to_ws_valid`=`ms2_to_ws_valid`=0;
  - buses are 0;
  - `ms1_reg`=`ms2_reg`=0.
- Latency from capture to valid: 1 cycle for a non-load. A load becomes valid in the cycle of `data_ok`, via the combinational bypass from `data_sram_rdata`.
- A `data_ok` arriving while WB stalls is stored in `ld_buf` the same edge. The lane is then served from `ld_buf` thereafter.
- Simultaneous events:
  - Lanes 1 and 2 may both transfer in one cycle.
  - A new capture may occur in the same cycle as the final transfer.
  - `ms_flush` overrides capture and transfer: no valid is asserted in the flush cycle.
- A `reset` during an outstanding load clears `discard`. The SRAM is reset in the same cycle.

## Configuration
- `MS_FWD_EN`:
  - When defined, `ms1_reg`/`ms2_reg` are driven as specified.
  - When undefined, both are tied to 0 and the forwarding logic is removed; ID then interlocks instead.

## Structure
- Add to `mycpu.h`: `ES_TO_MS_BUS_WD`, the ld_type codes, and the bus field bit positions.
- One sub-module, `ms_load_align`: purely combinational, taking (rdata, ld_type, addr_lo) and producing a 32-bit result. It is instantiated once, on the selected load lane.

## Test plan
- Two ALU instructions (pc 0xbfc00000/0xbfc00004), with WB allowin on both lanes. Expect both valids one cycle after capture, both transfers the same cycle, and `ms_allowin`=1.
- Lane 1 is lb at addr_lo=3 and `data_ok` returns 0x80112233 two cycles later. Expect result 0xffffff80, lane 2 withheld until lane 1 transfers, and `ms1_reg[41]`=0 while waiting.
- `ws_allowin_1`=1 and `ws_allowin_2`=0 for 3 cycles. Expect lane 1 sent once, `ms2_to_ws_valid` held high with a stable bus, and `ms_allowin`=0 until lane 2 transfers.
- lhu at addr_lo=2 with `data_ok` arriving while `ws_allowin_1`=0. Expect the buffered result 0x00008011, delivered when allowin rises.
- `ms_flush` while a load is pending, then `data_ok` 2 cycles later. Expect no valid output, that `data_ok` dropped, and `ms_allowin` returning to 1 the cycle after.
- Lane 1 load carrying ex=1. Expect no wait for `data_ok` and transfer one cycle after capture.

Source files
------------

// File: rtl/mem_stage_dual_pkg.sv
// Shared widths, load-type codes and bus field positions for the dual-lane MEM stage.
package mem_stage_dual_pkg;

  localparam int MS_TO_WS_BUS_WD = 133;
  localparam int ES_TO_MS_BUS_WD = 139;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  // EXE->MEM bus: {ld_en, ld_type, addr_lo, ws_base}
  localparam int ES_LD_EN_BIT   = 138;
  localparam int ES_LD_TYPE_HI  = 137;
  localparam int ES_LD_TYPE_LO  = 135;
  localparam int ES_ADDR_LO_HI  = 134;
  localparam int ES_ADDR_LO_LO  = 133;

  // Fields inside ws_base (the MEM->WB bus)
  localparam int WS_EX_BIT      = 122;
  localparam int WS_GR_WE_HI    = 72;
  localparam int WS_GR_WE_LO    = 69;
  localparam int WS_DEST_HI     = 68;
  localparam int WS_DEST_LO     = 64;
  localparam int WS_RES_HI      = 63;
  localparam int WS_RES_LO      = 32;

endpackage

// File: rtl/mem_stage_dual_ms_load_align.sv
// Load data alignment: picks the byte/halfword of the response word and extends it.
module ms_load_align
  import mem_stage_dual_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_result
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Extension select by load type
  always_comb begin
    o_result = i_rdata;
    case (ld_type_e'(i_ld_type))
      LD_W:    o_result = i_rdata;
      LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_result = {24'd0, w_byte};
      LD_H:    o_result = {{16{w_half[15]}}, w_half};
      LD_HU:   o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_dual.sv
// Dual-lane MEM stage: holds an EXE pair, merges the load response, hands lanes to WB in order.
// Optional MEM-level forwarding to ID is built when MS_FWD_EN is defined.
module mem_stage_dual
  import mem_stage_dual_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es1_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es1_to_ms_bus,
  input  logic                       es2_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es2_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ms_flush,
  output logic                       ms1_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms1_to_ws_bus,
  output logic                       ms2_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms2_to_ws_bus,
  input  logic                       ws_allowin_1,
  input  logic                       ws_allowin_2,
  output logic [41:0]                ms1_reg,
  output logic [41:0]                ms2_reg
);

  logic                       r_valid1, r_valid2, r_sent1, r_sent2;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus1, r_bus2;
  logic                       r_ld_pend, r_ld_buf_vld, r_discard;
  logic [31:0]                r_ld_buf;

  logic        w_is_ld1, w_is_ld2, w_data_ok, w_ready1, w_ready2;
  logic        w_xfer1, w_xfer2, w_capture, w_ld_lane2;
  logic [2:0]  w_ld_type;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_ld_word, w_ld_result;

  // A load flagged with an exception never issued a request, so it is treated like an ALU op
  assign w_is_ld1  = r_bus1[ES_LD_EN_BIT] & ~r_bus1[WS_EX_BIT];
  assign w_is_ld2  = r_bus2[ES_LD_EN_BIT] & ~r_bus2[WS_EX_BIT];
  assign w_data_ok = data_sram_data_ok & r_ld_pend & ~r_discard;
  assign w_ready1  = ~w_is_ld1 | r_ld_buf_vld | w_data_ok;
  assign w_ready2  = ~w_is_ld2 | r_ld_buf_vld | w_data_ok;

  assign ms1_to_ws_valid = r_valid1 & ~r_sent1 & w_ready1 & ~ms_flush;
  assign w_xfer1         = ms1_to_ws_valid & ws_allowin_1;
  assign ms2_to_ws_valid = r_valid2 & ~r_sent2 & w_ready2 & ~ms_flush
                         & (r_sent1 | w_xfer1 | ~r_valid1);
  assign w_xfer2         = ms2_to_ws_valid & ws_allowin_2;

  assign ms_allowin = ~r_discard & (~r_valid1 | r_sent1 | w_xfer1)
                                 & (~r_valid2 | r_sent2 | w_xfer2);
  assign w_capture  = ms_allowin & ~ms_flush;

  assign w_ld_lane2 = ~r_bus1[ES_LD_EN_BIT];
  assign w_ld_type  = w_ld_lane2 ? r_bus2[ES_LD_TYPE_HI:ES_LD_TYPE_LO] : r_bus1[ES_LD_TYPE_HI:ES_LD_TYPE_LO];
  assign w_addr_lo  = w_ld_lane2 ? r_bus2[ES_ADDR_LO_HI:ES_ADDR_LO_LO] : r_bus1[ES_ADDR_LO_HI:ES_ADDR_LO_LO];
  assign w_ld_word  = r_ld_buf_vld ? r_ld_buf : data_sram_rdata;

  ms_load_align u_align (
    .i_rdata   (w_ld_word),
    .i_ld_type (w_ld_type),
    .i_addr_lo (w_addr_lo),
    .o_result  (w_ld_result)
  );

  assign ms1_to_ws_bus = w_is_ld1
    ? {r_bus1[MS_TO_WS_BUS_WD-1:WS_RES_HI+1], w_ld_result, r_bus1[WS_RES_LO-1:0]}
    : r_bus1[MS_TO_WS_BUS_WD-1:0];
  assign ms2_to_ws_bus = w_is_ld2
    ? {r_bus2[MS_TO_WS_BUS_WD-1:WS_RES_HI+1], w_ld_result, r_bus2[WS_RES_LO-1:0]}
    : r_bus2[MS_TO_WS_BUS_WD-1:0];

  // Pair state, load tracking and post-flush response discard
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid1     <= 1'b0;
      r_valid2     <= 1'b0;
      r_sent1      <= 1'b0;
      r_sent2      <= 1'b0;
      r_bus1       <= '0;
      r_bus2       <= '0;
      r_ld_pend    <= 1'b0;
      r_ld_buf_vld <= 1'b0;
      r_ld_buf     <= 32'd0;
      r_discard    <= 1'b0;
    end else begin
      if (w_xfer1) r_sent1 <= 1'b1;
      if (w_xfer2) r_sent2 <= 1'b1;
      if (w_data_ok) begin
        r_ld_pend    <= 1'b0;
        r_ld_buf_vld <= 1'b1;
        r_ld_buf     <= data_sram_rdata;
      end
      if (r_discard && data_sram_data_ok) r_discard <= 1'b0;
      if (ms_flush) begin
        r_valid1     <= 1'b0;
        r_valid2     <= 1'b0;
        r_ld_buf_vld <= 1'b0;
        r_ld_pend    <= 1'b0;
        if (r_ld_pend && !data_sram_data_ok) r_discard <= 1'b1;
      end else if (w_capture) begin
        r_valid1     <= es1_to_ms_valid;
        r_valid2     <= es2_to_ms_valid;
        r_bus1       <= es1_to_ms_bus;
        r_bus2       <= es2_to_ms_bus;
        r_sent1      <= 1'b0;
        r_sent2      <= 1'b0;
        r_ld_buf_vld <= 1'b0;
        r_ld_pend    <= (es1_to_ms_valid & es1_to_ms_bus[ES_LD_EN_BIT] & ~es1_to_ms_bus[WS_EX_BIT])
                      | (es2_to_ms_valid & es2_to_ms_bus[ES_LD_EN_BIT] & ~es2_to_ms_bus[WS_EX_BIT]);
      end
    end
  end

`ifdef MS_FWD_EN
  logic w_fwd_ok1, w_fwd_ok2;
  assign w_fwd_ok1 = ~(r_valid1 & w_is_ld1 & ~w_ready1);
  assign w_fwd_ok2 = ~(r_valid2 & w_is_ld2 & ~w_ready2);
  assign ms1_reg = {w_fwd_ok1,
                    (r_valid1 & ~r_sent1) ? r_bus1[WS_GR_WE_HI:WS_GR_WE_LO] : 4'd0,
                    r_bus1[WS_DEST_HI:WS_DEST_LO], ms1_to_ws_bus[WS_RES_HI:WS_RES_LO]};
  assign ms2_reg = {w_fwd_ok2,
                    (r_valid2 & ~r_sent2) ? r_bus2[WS_GR_WE_HI:WS_GR_WE_LO] : 4'd0,
                    r_bus2[WS_DEST_HI:WS_DEST_LO], ms2_to_ws_bus[WS_RES_HI:WS_RES_LO]};
`else
  assign ms1_reg = 42'd0;
  assign ms2_reg = 42'd0;
`endif

endmodule

// File: tb/tb_mem_stage_dual.sv
// Directed self-checking bench for mem_stage_dual (default build, forwarding disabled).
module tb_mem_stage_dual;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es1_to_ms_valid, es2_to_ms_valid;
  logic [138:0] es1_to_ms_bus, es2_to_ms_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms_flush;
  logic         ms1_to_ws_valid, ms2_to_ws_valid;
  logic [132:0] ms1_to_ws_bus, ms2_to_ws_bus;
  logic         ws_allowin_1, ws_allowin_2;
  logic [41:0]  ms1_reg, ms2_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_dual dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es1_to_ms_valid   (es1_to_ms_valid),
    .es1_to_ms_bus     (es1_to_ms_bus),
    .es2_to_ms_valid   (es2_to_ms_valid),
    .es2_to_ms_bus     (es2_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_flush          (ms_flush),
    .ms1_to_ws_valid   (ms1_to_ws_valid),
    .ms1_to_ws_bus     (ms1_to_ws_bus),
    .ms2_to_ws_valid   (ms2_to_ws_valid),
    .ms2_to_ws_bus     (ms2_to_ws_bus),
    .ws_allowin_1      (ws_allowin_1),
    .ws_allowin_2      (ws_allowin_2),
    .ms1_reg           (ms1_reg),
    .ms2_reg           (ms2_reg)
  );

  // ws_base layout: ex[122], gr_we[72:69], dest[68:64], result[63:32], pc[31:0]
  function automatic logic [132:0] mk_ws(input logic ex, input logic [3:0] we, input logic [4:0] dest,
                                         input logic [31:0] res, input logic [31:0] pc);
    logic [132:0] b;
    b          = '0;
    b[122]     = ex;
    b[72:69]   = we;
    b[68:64]   = dest;
    b[63:32]   = res;
    b[31:0]    = pc;
    return b;
  endfunction

  function automatic logic [138:0] mk_es(input logic ld, input logic [2:0] ty, input logic [1:0] lo,
                                         input logic [132:0] ws);
    return {ld, ty, lo, ws};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    es1_to_ms_valid   = 1'b0;
    es2_to_ms_valid   = 1'b0;
    es1_to_ms_bus     = '0;
    es2_to_ms_bus     = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    ms_flush          = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ws_allowin_1 = 1'b0;
    ws_allowin_2 = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%b exp=1", ms_allowin); end
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", ms1_to_ws_valid, ms2_to_ws_valid); end
    total++; if ({ms1_to_ws_bus, ms2_to_ws_bus} !== 266'd0) begin bad++; $display("FAIL rst_bus got=%h/%h exp=0", ms1_to_ws_bus, ms2_to_ws_bus); end
    total++; if ({ms1_reg, ms2_reg} !== 84'd0) begin bad++; $display("FAIL rst_fwd got=%h/%h exp=0", ms1_reg, ms2_reg); end
  endtask

  task automatic test_alu_pair();
    logic [132:0] a, b, c, d;
    a = mk_ws(1'b0, 4'hf, 5'd1, 32'h0000_0011, 32'hbfc0_0000);
    b = mk_ws(1'b0, 4'hf, 5'd2, 32'h0000_0022, 32'hbfc0_0004);
    c = mk_ws(1'b0, 4'hf, 5'd3, 32'h0000_0033, 32'hbfc0_0008);
    d = mk_ws(1'b0, 4'hf, 5'd4, 32'h0000_0044, 32'hbfc0_000c);
    ws_allowin_1 = 1'b1;
    ws_allowin_2 = 1'b1;
    es1_to_ms_valid = 1'b1; es1_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, a);
    es2_to_ms_valid = 1'b1; es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, b);
    tick();
    es1_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, c);
    es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, d);
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b11) begin bad++; $display("FAIL alu_valid got=%b%b exp=11", ms1_to_ws_valid, ms2_to_ws_valid); end
    total++; if (ms1_to_ws_bus !== a || ms2_to_ws_bus !== b) begin bad++; $display("FAIL alu_bus got=%h/%h exp=%h/%h", ms1_to_ws_bus, ms2_to_ws_bus, a, b); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL alu_allowin got=%b exp=1", ms_allowin); end
    tick();
    es1_to_ms_valid = 1'b0;
    es2_to_ms_valid = 1'b0;
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b11 || ms1_to_ws_bus !== c || ms2_to_ws_bus !== d) begin
      bad++; $display("FAIL b2b_pair got=%b%b %h/%h exp=11 %h/%h", ms1_to_ws_valid, ms2_to_ws_valid, ms1_to_ws_bus, ms2_to_ws_bus, c, d); end
    tick();
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00 || ms_allowin !== 1'b1) begin
      bad++; $display("FAIL alu_drain got=%b%b allowin=%b exp=00 1", ms1_to_ws_valid, ms2_to_ws_valid, ms_allowin); end
  endtask

  task automatic test_load_lb();
    logic [132:0] a, b, ea;
    a  = mk_ws(1'b0, 4'hf, 5'd5, 32'd0, 32'hbfc0_0010);
    b  = mk_ws(1'b0, 4'hf, 5'd6, 32'h0000_0066, 32'hbfc0_0014);
    ea = mk_ws(1'b0, 4'hf, 5'd5, 32'hffff_ff80, 32'hbfc0_0010);
    es1_to_ms_valid = 1'b1; es1_to_ms_bus = mk_es(1'b1, 3'd1, 2'd3, a);
    es2_to_ms_valid = 1'b1; es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, b);
    tick();
    idle_inputs();
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00 || ms_allowin !== 1'b0) begin
      bad++; $display("FAIL lb_wait got=%b%b allowin=%b exp=00 0", ms1_to_ws_valid, ms2_to_ws_valid, ms_allowin); end
    total++; if (ms1_reg[41] !== 1'b0) begin bad++; $display("FAIL lb_fwd_ok got=%b exp=0", ms1_reg[41]); end
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8011_2233;
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b11 || ms_allowin !== 1'b1) begin
      bad++; $display("FAIL lb_valid got=%b%b allowin=%b exp=11 1", ms1_to_ws_valid, ms2_to_ws_valid, ms_allowin); end
    total++; if (ms1_to_ws_bus !== ea || ms2_to_ws_bus !== b) begin
      bad++; $display("FAIL lb_bus got=%h/%h exp=%h/%h", ms1_to_ws_bus, ms2_to_ws_bus, ea, b); end
    tick();
    idle_inputs();
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin bad++; $display("FAIL lb_drain got=%b%b exp=00", ms1_to_ws_valid, ms2_to_ws_valid); end
  endtask

  task automatic test_lane2_stall();
    logic [132:0] a, b;
    a = mk_ws(1'b0, 4'h1, 5'd7, 32'h0000_0077, 32'hbfc0_0020);
    b = mk_ws(1'b0, 4'h3, 5'd8, 32'h0000_0088, 32'hbfc0_0024);
    ws_allowin_1 = 1'b1;
    ws_allowin_2 = 1'b0;
    es1_to_ms_valid = 1'b1; es1_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, a);
    es2_to_ms_valid = 1'b1; es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, b);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ms1_to_ws_valid !== (i == 0) || ms2_to_ws_valid !== 1'b1 || ms2_to_ws_bus !== b) begin
        bad++; $display("FAIL stall_c%0d got=%b%b %h exp=%b1 %h", i, ms1_to_ws_valid, ms2_to_ws_valid, ms2_to_ws_bus, (i == 0), b); end
      total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL stall_allowin_c%0d got=%b exp=0", i, ms_allowin); end
      tick();
    end
    ws_allowin_2 = 1'b1;
    #1;
    total++; if (ms2_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%b allowin=%b exp=1 1", ms2_to_ws_valid, ms_allowin); end
    tick();
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin bad++; $display("FAIL stall_drain got=%b%b exp=00", ms1_to_ws_valid, ms2_to_ws_valid); end
  endtask

  task automatic test_lhu_buffered();
    logic [132:0] a, b, ea;
    a  = mk_ws(1'b0, 4'hf, 5'd9, 32'd0, 32'hbfc0_0030);
    b  = mk_ws(1'b0, 4'hf, 5'd10, 32'h0000_00aa, 32'hbfc0_0034);
    ea = mk_ws(1'b0, 4'hf, 5'd9, 32'h0000_8011, 32'hbfc0_0030);
    ws_allowin_1 = 1'b0;
    ws_allowin_2 = 1'b1;
    es1_to_ms_valid = 1'b1; es1_to_ms_bus = mk_es(1'b1, 3'd4, 2'd2, a);
    es2_to_ms_valid = 1'b1; es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, b);
    tick();
    idle_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8011_2233;
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b10 || ms1_to_ws_bus !== ea) begin
      bad++; $display("FAIL lhu_bypass got=%b%b %h exp=10 %h", ms1_to_ws_valid, ms2_to_ws_valid, ms1_to_ws_bus, ea); end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hdead_beef;
    #1;
    total++; if (ms1_to_ws_valid !== 1'b1 || ms1_to_ws_bus !== ea) begin
      bad++; $display("FAIL lhu_buffered got=%b %h exp=1 %h", ms1_to_ws_valid, ms1_to_ws_bus, ea); end
    tick();
    ws_allowin_1 = 1'b1;
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b11 || ms1_to_ws_bus !== ea || ms_allowin !== 1'b1) begin
      bad++; $display("FAIL lhu_deliver got=%b%b %h allowin=%b exp=11 %h 1", ms1_to_ws_valid, ms2_to_ws_valid, ms1_to_ws_bus, ms_allowin, ea); end
    tick();
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin bad++; $display("FAIL lhu_drain got=%b%b exp=00", ms1_to_ws_valid, ms2_to_ws_valid); end
  endtask

  task automatic test_flush();
    logic [132:0] a, b;
    a = mk_ws(1'b0, 4'hf, 5'd11, 32'd0, 32'hbfc0_0040);
    b = mk_ws(1'b0, 4'hf, 5'd12, 32'h0000_00cc, 32'hbfc0_0044);
    es1_to_ms_valid = 1'b1; es1_to_ms_bus = mk_es(1'b1, 3'd0, 2'd0, a);
    es2_to_ms_valid = 1'b1; es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, b);
    tick();
    idle_inputs();
    ms_flush = 1'b1;
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin bad++; $display("FAIL flush_cycle got=%b%b exp=00", ms1_to_ws_valid, ms2_to_ws_valid); end
    tick();
    ms_flush = 1'b0;
    #1;
    total++; if (ms_allowin !== 1'b0 || {ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin
      bad++; $display("FAIL flush_discard got=allowin %b valid %b%b exp=0 00", ms_allowin, ms1_to_ws_valid, ms2_to_ws_valid); end
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00 || ms_allowin !== 1'b0) begin
      bad++; $display("FAIL flush_drop got=%b%b allowin=%b exp=00 0", ms1_to_ws_valid, ms2_to_ws_valid, ms_allowin); end
    tick();
    idle_inputs();
    #1;
    total++; if (ms_allowin !== 1'b1 || {ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00) begin
      bad++; $display("FAIL flush_recover got=allowin %b valid %b%b exp=1 00", ms_allowin, ms1_to_ws_valid, ms2_to_ws_valid); end
  endtask

  task automatic test_ex_load();
    logic [132:0] a, b;
    a = mk_ws(1'b1, 4'h0, 5'd13, 32'h5555_aaaa, 32'hbfc0_0050);
    b = mk_ws(1'b0, 4'hf, 5'd14, 32'h0000_00ee, 32'hbfc0_0054);
    ws_allowin_1 = 1'b1;
    ws_allowin_2 = 1'b1;
    es1_to_ms_valid = 1'b1; es1_to_ms_bus = mk_es(1'b1, 3'd1, 2'd1, a);
    es2_to_ms_valid = 1'b1; es2_to_ms_bus = mk_es(1'b0, 3'd0, 2'd0, b);
    tick();
    idle_inputs();
    #1;
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b11 || ms1_to_ws_bus !== a) begin
      bad++; $display("FAIL ex_load got=%b%b %h exp=11 %h", ms1_to_ws_valid, ms2_to_ws_valid, ms1_to_ws_bus, a); end
    tick();
    total++; if ({ms1_to_ws_valid, ms2_to_ws_valid} !== 2'b00 || ms_allowin !== 1'b1) begin
      bad++; $display("FAIL ex_drain got=%b%b allowin=%b exp=00 1", ms1_to_ws_valid, ms2_to_ws_valid, ms_allowin); end
  endtask

  initial begin
    test_reset();
    test_alu_pair();
    test_load_lb();
    test_lane2_stall();
    test_lhu_buffered();
    test_flush();
    test_ex_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
